// File: rtl/rf_multiport.sv
// Multi-port register file: two write ports, NRD read ports, a debug read port and a
// sequenced full-array clear. Define RF_MULTIPORT_BYPASS_EN to forward write data to the read ports.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | normal operation, writes accepted, reads from array
//  ST_CLEAR | zeroing entry r_clr_ptr each cycle, writes dropped, reads 0
module rf_multiport #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we0,
   input  logic [ADDR_W-1:0]     wa0,
   input  logic [DATA_W-1:0]     wd0,
   input  logic                  we1,
   input  logic [ADDR_W-1:0]     wa1,
   input  logic [DATA_W-1:0]     wd1,
   input  logic [NRD*ADDR_W-1:0] ra,
   output logic [NRD*DATA_W-1:0] rd,
   input  logic [ADDR_W-1:0]     dbg_sel,
   output logic [DATA_W-1:0]     dbg_data,
   input  logic                  clr_req,
   output logic                  busy
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_clr_ptr;
   logic [ADDR_W-1:0]   w_clr_ptr_nxt;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic                w_busy;
   logic                w_wr0;
   logic                w_wr1;
   logic [DATA_W-1:0]   w_dbg;

   assign w_busy = (r_state == ST_CLEAR);
   assign busy   = w_busy;

   // Effective writes: qualified by state, reset and the hardwired zero entry.
   assign w_wr0 = we0 && !rst && !w_busy && !((ZERO_REG != 0) && (wa0 == '0));
   assign w_wr1 = we1 && !rst && !w_busy && !((ZERO_REG != 0) && (wa1 == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_CLEAR;
         r_clr_ptr <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_ptr <= w_clr_ptr_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_ptr_nxt = r_clr_ptr;
      case (r_state)
         ST_IDLE: begin
            if (clr_req) begin
               w_state_nxt   = ST_CLEAR;
               w_clr_ptr_nxt = '0;
            end
         end
         ST_CLEAR: begin
            w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
            if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt   = ST_CLEAR;
            w_clr_ptr_nxt = '0;
         end
      endcase
   end

   // Port 1 is written last so it wins an address collision.
   always_ff @(posedge clk) begin
      if (!rst && w_busy) begin
         r_mem[r_clr_ptr] <= '0;
      end
      if (w_wr0) begin
         r_mem[wa0] <= wd0;
      end
      if (w_wr1) begin
         r_mem[wa1] <= wd1;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rd;

      assign w_ra = ra[k*ADDR_W +: ADDR_W];

      always_comb begin
         w_rd = r_mem[w_ra];
         if ((ZERO_REG != 0) && (w_ra == '0)) begin
            w_rd = '0;
         end
`ifdef RF_MULTIPORT_BYPASS_EN
         if (w_wr0 && (wa0 == w_ra)) begin
            w_rd = wd0;
         end
         if (w_wr1 && (wa1 == w_ra)) begin
            w_rd = wd1;
         end
`endif
         if (w_busy) begin
            w_rd = '0;
         end
      end

      assign rd[k*DATA_W +: DATA_W] = w_rd;
   end

   // Debug port always shows stored state, never in-flight write data.
   always_comb begin
      w_dbg = r_mem[dbg_sel];
      if (((ZERO_REG != 0) && (dbg_sel == '0)) || w_busy) begin
         w_dbg = '0;
      end
   end

   assign dbg_data = w_dbg;

endmodule
